// File: rtl/pts_stream_serializer_pkg.sv
// Shared types, defaults and helpers for the parallel-to-serial stream serializer.
// Optional build macro: PTS_BIT_REVERSE_EN (emit lanes in FFT bit-reversed order).
package pts_pkg;

    localparam int PTS_NUM_LANES = 32;
    localparam int PTS_DATA_W    = 16;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } pts_state_e;

    // Reverse the low 'width' bits of value; upper bits of the result are zero.
    function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int width);
        logic [31:0] result;
        result = '0;
        for (int i = 0; i < width; i++) begin
            result[i] = value[width - 1 - i];
        end
        return result;
    endfunction

endpackage

// File: rtl/pts_stream_serializer_if.sv
// Load/stream handshake bundle between the FFT parallel output and the serial port.
// slave = serializer side, master = producer/consumer side.
interface pts_stream_serializer_if #(
    parameter int NUM_LANES = 32,
    parameter int DATA_W    = 16,
    parameter int IDX_W     = $clog2(NUM_LANES)
) ();
    logic                        load_strobe;
    logic [NUM_LANES*DATA_W-1:0] par_in;
    logic                        load_ready;
    logic                        load_overflow;
    logic [DATA_W-1:0]           serial_out;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_last;
    logic [IDX_W-1:0]            out_index;
    logic                        busy;

    modport slave (
        input  load_strobe, par_in, out_ready,
        output load_ready, load_overflow, serial_out, out_valid, out_last, out_index, busy
    );

    modport master (
        output load_strobe, par_in, out_ready,
        input  load_ready, load_overflow, serial_out, out_valid, out_last, out_index, busy
    );
endinterface

// File: rtl/pts_stream_serializer_lane_counter.sv
// Lane counter: clears on promotion, advances per transferred word, wraps naturally.
// With PTS_BIT_REVERSE_EN defined the emitted lane index is the bit-reversed count.
module pts_lane_counter
    import pts_pkg::*;
#(
    parameter int NUM_LANES = PTS_NUM_LANES,
    localparam int IDX_W    = $clog2(NUM_LANES)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             promote_i,
    input  logic             advance_i,
    output logic [IDX_W-1:0] out_index_o,
    output logic             is_last_o
);
    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (promote_i) begin
            cnt_d = '0;
        end else if (advance_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // out_last tracks the transfer count, not the emitted lane number.
    assign is_last_o = (cnt_q == IDX_W'(NUM_LANES - 1));

`ifdef PTS_BIT_REVERSE_EN
    logic [31:0] rev_full;
    assign rev_full    = bit_reverse(32'(cnt_q), IDX_W);
    assign out_index_o = rev_full[IDX_W-1:0];
`else
    assign out_index_o = cnt_q;
`endif

endmodule

// File: rtl/pts_stream_serializer.sv
// Double-buffered parallel-to-serial converter: a shadow frame loads while the active frame drains.
// Lane order is selected by PTS_BIT_REVERSE_EN (see the lane counter).
module pts_stream_serializer
    import pts_pkg::*;
#(
    parameter int NUM_LANES = PTS_NUM_LANES,
    parameter int DATA_W    = PTS_DATA_W
) (
    input  logic                    clk,
    input  logic                    n_rst,
    pts_stream_serializer_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_LANES);

    pts_state_e        state_q, state_d;
    logic              shadow_full_q, shadow_full_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] active_q [NUM_LANES];
    logic [DATA_W-1:0] shadow_q [NUM_LANES];

    logic              out_valid;
    logic              load_acc;
    logic              xfer;
    logic              last_xfer;
    logic              promote;
    logic              is_last;
    logic [IDX_W-1:0]  lane_idx;

    assign out_valid = (state_q == STREAM);
    assign load_acc  = bus.load_strobe && !shadow_full_q;
    assign xfer      = out_valid && bus.out_ready;
    assign last_xfer = xfer && is_last;
    assign promote   = shadow_full_q && ((state_q == IDLE) || last_xfer);

    pts_lane_counter #(.NUM_LANES(NUM_LANES)) u_lane_counter (
        .clk         (clk),
        .n_rst       (n_rst),
        .promote_i   (promote),
        .advance_i   (xfer && !promote),
        .out_index_o (lane_idx),
        .is_last_o   (is_last)
    );

    // A load and a promotion can never coincide: promotion needs the shadow full, a load needs it empty.
    always_comb begin
        shadow_full_d = shadow_full_q;
        state_d       = state_q;
        overflow_d    = bus.load_strobe && shadow_full_q;
        if (load_acc) begin
            shadow_full_d = 1'b1;
        end else if (promote) begin
            shadow_full_d = 1'b0;
        end
        if (promote) begin
            state_d = STREAM;
        end else if (last_xfer) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            shadow_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_full_q <= shadow_full_d;
            overflow_q    <= overflow_d;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (load_acc) begin
                    shadow_q[i] <= bus.par_in[i*DATA_W +: DATA_W];
                end
                if (promote) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

    assign bus.serial_out    = active_q[lane_idx];
    assign bus.out_index     = lane_idx;
    assign bus.out_valid     = out_valid;
    assign bus.out_last      = is_last && out_valid;
    assign bus.load_ready    = !shadow_full_q;
    assign bus.load_overflow = overflow_q;
    assign bus.busy          = out_valid || shadow_full_q;

endmodule

// File: tb/tb_pts_stream_serializer.sv
// Directed bench for pts_stream_serializer (NUM_LANES=32, DATA_W=16); lane i of a frame holds base+i.
// Honours PTS_BIT_REVERSE_EN when computing the expected lane order.
module tb_pts_stream_serializer;
    localparam int NL = 32;
    localparam int DW = 16;

    logic clk;
    logic n_rst;
    int   n_checks;
    int   n_fail;

    pts_stream_serializer_if #(.NUM_LANES(NL), .DATA_W(DW)) bus ();

    pts_stream_serializer #(.NUM_LANES(NL), .DATA_W(DW)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NL*DW-1:0] make_frame(input logic [15:0] base);
        logic [NL*DW-1:0] f;
        for (int i = 0; i < NL; i++) f[i*DW +: DW] = base + 16'(i);
        return f;
    endfunction

    // Expected source lane of the k-th transferred word.
    function automatic int lane_of(input int k);
`ifdef PTS_BIT_REVERSE_EN
        int r;
        r = 0;
        for (int b = 0; b < 5; b++) if (((k >> b) & 1) != 0) r |= (1 << (4 - b));
        return r;
`else
        return k;
`endif
    endfunction

    task automatic load_frame(input logic [15:0] base);
        bus.load_strobe = 1'b1;
        bus.par_in      = make_frame(base);
        tick();
        bus.load_strobe = 1'b0;
        check("load_valid_lat", 32'(bus.out_valid), 32'd0);
        check("load_busy", 32'(bus.busy), 32'd1);
        check("load_ready_low", 32'(bus.load_ready), 32'd0);
        tick();
    endtask

    // Drain one whole frame; optional loads injected at cycles inj1/inj2 (-1 = none).
    task automatic drain(input logic [15:0] base, input bit bp,
                         input int inj1, input logic [15:0] b1,
                         input int inj2, input logic [15:0] b2, input bit exp_ovf2);
        int  k;
        int  cyc;
        int  ln;
        bit  xfer;
        k   = 0;
        cyc = 0;
        while (k < NL) begin
            ln = lane_of(k);
            bus.out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            check("out_valid", 32'(bus.out_valid), 32'd1);
            check("serial_out", 32'(bus.serial_out), 32'(16'(base + 16'(ln))));
            check("out_index", 32'(bus.out_index), 32'(ln));
            check("out_last", 32'(bus.out_last), 32'(k == NL - 1));
            if (inj1 >= 0 && cyc == inj1 + 1) begin
                check("ovf_after_load", 32'(bus.load_overflow), 32'd0);
                check("ready_after_load", 32'(bus.load_ready), 32'd0);
            end
            if (inj2 >= 0 && cyc == inj2 + 1) check("ovf_pulse", 32'(bus.load_overflow), 32'(exp_ovf2));
            if (inj2 >= 0 && cyc == inj2 + 2) check("ovf_one_cycle", 32'(bus.load_overflow), 32'd0);
            bus.load_strobe = (cyc == inj1) || (cyc == inj2);
            bus.par_in      = (cyc == inj1) ? make_frame(b1) : make_frame(b2);
            xfer = bus.out_ready;
            tick();
            bus.load_strobe = 1'b0;
            if (xfer) k++;
            cyc++;
        end
        $display("frame base=%04h drained in %0d cycles (backpressure=%0b)", base, cyc, bp);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_ready"}, 32'(bus.load_ready), 32'd1);
        check({tag, "_last"}, 32'(bus.out_last), 32'd0);
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        n_rst           = 1'b0;
        bus.load_strobe = 1'b0;
        bus.par_in      = '0;
        bus.out_ready   = 1'b1;

        // Reset state
        tick();
        tick();
        check_idle("rst");
        check("rst_ovf", 32'(bus.load_overflow), 32'd0);
        check("rst_serial", 32'(bus.serial_out), 32'd0);
        check("rst_index", 32'(bus.out_index), 32'd0);
        n_rst = 1'b1;
        tick();
        check_idle("post_rst");

        // Single frame, no backpressure
        load_frame(16'h0000);
        drain(16'h0000, 1'b0, -1, 16'h0, -1, 16'h0, 1'b0);
        check_idle("single_end");

        // Backpressure pattern 1,0,0,1
        load_frame(16'h0000);
        drain(16'h0000, 1'b1, -1, 16'h0, -1, 16'h0, 1'b0);
        check_idle("bp_end");

        // Back-to-back with an overflowing third load
        load_frame(16'h0000);
        drain(16'h0000, 1'b0, 2, 16'h0100, 5, 16'h0200, 1'b1);
        check("b2b_ready", 32'(bus.load_ready), 32'd1);
        check("b2b_busy", 32'(bus.busy), 32'd1);
        drain(16'h0100, 1'b1, -1, 16'h0, -1, 16'h0, 1'b0);
        check_idle("b2b_end");
        tick();
        tick();
        check_idle("no_third_frame");

        // Reset mid-frame with a pending shadow
        load_frame(16'h0000);
        bus.out_ready = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            bus.load_strobe = (k == 5);
            bus.par_in      = make_frame(16'h0100);
            tick();
            bus.load_strobe = 1'b0;
        end
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        check("pre_rst_ready", 32'(bus.load_ready), 32'd0);
        n_rst = 1'b0;
        #1;
        check_idle("mid_rst");
        tick();
        n_rst = 1'b1;
        tick();
        check_idle("after_rst");
        load_frame(16'h0000);
        drain(16'h0000, 1'b0, -1, 16'h0, -1, 16'h0, 1'b0);
        check_idle("restart_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pts_stream_serializer.md
Name: pts_stream_serializer

Overview:
- Parametrised parallel-to-serial converter for the FFT output path.
- Captures NUM_LANES words of DATA_W bits in one cycle and streams them one word per accepted cycle over a valid/ready interface.
- Double-buffered: a shadow frame loads while the active frame drains, so back-to-back frames stream with no bubble.
- Sits between the FFT butterfly array's parallel output and the serial output port; supersedes the fixed 32x16 PtS wrapper.

Parameters:
- NUM_LANES, 32, words per frame; power of two, >= 2.
- DATA_W, 16, bits per word.
- IDX_W, $clog2(NUM_LANES), derived lane-index width; not overridden.

Ports:
- clk  in  1  system clock, rising-edge.
- n_rst  in  1  asynchronous, active-low reset.
- load_strobe  in  1  capture par_in this cycle.
- par_in  in  NUM_LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W].
- load_ready  out  1  shadow buffer empty; a load is accepted.
- load_overflow  out  1  one-cycle pulse: load_strobe seen while load_ready=0.
- serial_out  out  DATA_W  current word.
- out_valid  out  1  serial_out/out_index/out_last valid.
- out_ready  in  1  downstream accepts the current word.
- out_last  out  1  current word is the final word of the frame.
- out_index  out  IDX_W  source lane of the current word.
- busy  out  1  active frame streaming or shadow frame pending.

Behaviour:
- Clocking and reset: one clock domain (clk); reset is asynchronous, active-low (n_rst).
- Reset values:
  - All outputs 0, except load_ready=1.
  - Counter 0, shadow empty, state IDLE.
  - Both buffers discarded; assertion mid-frame aborts the frame immediately, with no further out_valid.
- Storage: active frame register, shadow frame register, shadow_full flag, lane counter cnt (IDX_W bits).
- States:
  - IDLE: no active frame.
  - STREAM: active frame draining.
- Load:
  - If load_strobe && load_ready at edge k, par_in is written to the shadow and shadow_full=1.
  - load_ready = !shadow_full; registered-state only, never combinational from load_strobe.
  - If load_strobe && !load_ready, the load is dropped, the shadow is unchanged, and load_overflow pulses for exactly one cycle after that edge.
- Promotion (shadow to active, cnt=0, shadow_full=0, state=STREAM) occurs at an edge when shadow_full and either:
  - state is IDLE, or
  - the last word is transferred at that edge.
- Latency: load at edge k, then promotion at edge k+1, then out_valid=1 after edge k+1.
- Transfer:
  - A word transfers when out_valid && out_ready, and cnt increments.
  - While out_valid && !out_ready, serial_out, out_index and out_last hold stable.
- Last word: out_last = (cnt == NUM_LANES-1) && out_valid. On its transfer:
  - shadow_full: promote, giving zero bubble; the next word is valid the following cycle.
  - otherwise: go to IDLE, out_valid=0.
- Simultaneous load and promotion at the same edge: load_ready was 0 that cycle, so the load is dropped and flagged as overflow. No same-cycle bypass.
- Output select: serial_out = active[out_index]; out_index = map(cnt).
- busy = (state==STREAM) || shadow_full.
- cnt wraps naturally from NUM_LANES-1 to 0 at promotion; no explicit modulo.

Optional Feature:
- PTS_BIT_REVERSE_EN:
  - Defined: map(cnt) = bit-reverse of cnt over IDX_W bits, so lanes are emitted in FFT bit-reversed order. For NUM_LANES=32 the order is 0,16,8,24,4,...,31. out_last still marks the 32nd transfer (lane 31).
  - Undefined: map(cnt) = cnt (ascending lanes 0..NUM_LANES-1).
  - Latency and handshake are identical in both builds.

Decomposition:
- Package pts_pkg:
  - state enum {IDLE, STREAM}.
  - function bit_reverse(value, width).
  - Default lane/width localparams shared with the FFT top.
- Sub-module pts_lane_counter:
  - Holds cnt with increment, clear-on-promote and wrap.
  - Outputs the mapped out_index (honours PTS_BIT_REVERSE_EN) and the is_last flag.
- Top module holds both buffers, the FSM and the output mux.

Test Plan (NUM_LANES=32, DATA_W=16, lane i = 16'h00i):
- Single frame, out_ready=1:
  - Load at edge k gives out_valid after k+1; serial_out runs 0000..001F over 32 cycles.
  - out_last only on 001F; then IDLE, busy=0.
- Backpressure: out_ready toggles 1,0,0,1 repeating -> every word appears once, in order, and is held stable while ready=0; total 32 transfers.
- Back-to-back:
  - Frame A of 00i is streaming; load frame B of 01i.
  - After A's word 001F, B's 0100 is valid the very next cycle; load_ready returns to 1 after promotion.
- Overflow:
  - Shadow full plus a third load_strobe -> load_overflow pulses 1 cycle.
  - The third frame never appears; frames A and B are output intact.
- Reset mid-frame: n_rst low after word 000A -> out_valid=0, load_ready=1, busy=0 immediately; a fresh load restarts at 0000.
- PTS_BIT_REVERSE_EN defined -> out_index sequence 0,16,8,24,4,20,...,31 with serial_out equal to out_index; out_last on index 31.
